// File: rtl/otter_fetch_queue.sv
// OTTER instruction-fetch front end: owns the fetch PC, issues word reads
// and buffers {pc, instr} in a small FIFO drained by decode.
module otter_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       REDIRECT,
  input  logic [31:0]                REDIRECT_PC,
  output logic                       MEM_RDEN1,
  output logic [ADDR_W-1:0]          MEM_ADDR1,
  input  logic [31:0]                MEM_DOUT1,
  output logic                       ID_VALID,
  input  logic                       ID_READY,
  output logic [31:0]                ID_PC,
  output logic [31:0]                ID_NPC,
  output logic [31:0]                ID_INSTR,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occ;
  logic          unused_bits;

  assign unused_bits = ^REDIRECT_PC[1:0];

  assign pop  = (count != '0) & ID_READY;
  assign push = inflight & ~REDIRECT;

  // credit counts the read in flight so a response always has a slot
  assign occ = {1'b0, count}
             + (CW+1)'(inflight)
             - (CW+1)'(pop);

  assign issue     = RST_N & ~REDIRECT & (occ < DEPTH_C);
  assign MEM_RDEN1 = issue;
  assign MEM_ADDR1 = fetch_pc[ADDR_W+1:2];

  assign ID_VALID = (count != '0);
  assign ID_PC    = pc_q[rd_ptr];
  assign ID_NPC   = ID_PC + 32'd4;
  assign ID_INSTR = instr_q[rd_ptr];
  assign COUNT    = count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_pc    <= RESET_VEC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (REDIRECT) begin
      fetch_pc <= {REDIRECT_PC[31:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      assert (!(push && !pop && count == FULL));
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      if (push) begin
        pc_q[wr_ptr]    <= inflight_pc;
        instr_q[wr_ptr] <= MEM_DOUT1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule
